// File: rtl/graph_act_lut.sv
// Multi-bank int8 activation lookup: LANES bytes per beat are mapped through one of
// NBANKS loadable 256-entry tables, through a two-stage (read, output) stallable pipeline.
`timescale 1ns/1ps

module graph_act_lut #(
    parameter int LANES  = 4,
    parameter int NBANKS = 4,
    parameter int BW     = $clog2(NBANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [BW-1:0]        cfg_bank,
    input  logic [7:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    input  logic                 cfg_commit,
    input  logic                 cfg_invalidate,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BW-1:0]        in_bank,
    input  logic [LANES*8-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_data,
    output logic [NBANKS-1:0]    bank_valid,
    output logic                 err_sticky
);

    // One read port per lane into a shared array; the tool replicates it per lane.
    logic [7:0]          r_table [NBANKS][256];

    logic                r_s1_valid;
    logic [LANES*8-1:0]  r_s1_data;
    logic                r_out_valid;
    logic [LANES*8-1:0]  r_out_data;
    logic [NBANKS-1:0]   r_bank_valid;
    logic                r_err;

    logic                w_stall;
    logic                w_accept;
    logic                w_bank_hit;
    logic [LANES*8-1:0]  w_lookup;

    assign w_stall    = r_out_valid && !out_ready;
    assign in_ready   = !w_stall;
    assign w_accept   = in_valid && in_ready;

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign bank_valid = r_bank_valid;
    assign err_sticky = r_err;

    // Out-of-range bank codes never match, so they behave as uncommitted.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_bank_hit = 1'b0;
        for (int b = 0; b < NBANKS; b++) begin
            if (in_bank == BW'(b) && r_bank_valid[b]) begin
                w_bank_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_lookup = '0;
        if (w_bank_hit) begin
            for (int i = 0; i < LANES; i++) begin
                w_lookup[8*i +: 8] = r_table[in_bank][in_data[8*i +: 8]];
            end
        end
    end

    // NOTE: table contents are deliberately not reset, so they survive rst_n and map onto RAM.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_table[cfg_bank][cfg_addr] <= cfg_wdata;
        end
    end

    // Invalidate takes priority over a simultaneous commit of the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_valid <= '0;
        end else if (cfg_invalidate) begin
            r_bank_valid[cfg_bank] <= 1'b0;
        end else if (cfg_commit) begin
            r_bank_valid[cfg_bank] <= 1'b1;
        end
    end

    // NOTE: non-blocking assignments let S2 capture the pre-edge S1 value within one block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid;
            r_s1_data   <= w_lookup;
            r_out_valid <= r_s1_valid;
            r_out_data  <= r_s1_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_bank_hit) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_graph_act_lut.sv
// Bench for graph_act_lut: directed scenarios plus random traffic, all checked against a
// table/queue model of the lookup behaviour sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_graph_act_lut;

    localparam int LANES  = 4;
    localparam int NBANKS = 4;
    localparam int BW     = 2;
    localparam int DW     = LANES * 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_we = 1'b0;
    logic [BW-1:0]  cfg_bank = '0;
    logic [7:0]     cfg_addr = '0;
    logic [7:0]     cfg_wdata = '0;
    logic           cfg_commit = 1'b0;
    logic           cfg_invalidate = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [BW-1:0]  in_bank = '0;
    logic [DW-1:0]  in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  out_data;
    logic [NBANKS-1:0] bank_valid;
    logic           err_sticky;

    graph_act_lut #(.LANES(LANES), .NBANKS(NBANKS), .BW(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .cfg_invalidate(cfg_invalidate),
        .in_valid(in_valid), .in_ready(in_ready), .in_bank(in_bank), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .bank_valid(bank_valid), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;
    int n_out   = 0;

    // Reference model: table contents, committed flags, sticky error, and beats in flight.
    logic [7:0]        mmem [NBANKS][256];
    logic [NBANKS-1:0] mv = '0;
    logic              merr = 1'b0;
    logic [DW-1:0]     q [$];
    logic              prev_stall = 1'b0;
    logic [DW-1:0]     prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_val(input logic [7:0] code);
        int  si;
        int  r;
        real v;
        si = int'($signed(code));
        v  = 32.0 * $exp(real'(si) / 32.0);
        r  = $rtoi(v + 0.5);
        if (r > 127) r = 127;
        return 8'(r);
    endfunction

    // Everything sampled here refers to the upcoming rising edge: lookups see the table
    // before this edge's write, and config changes become visible after it.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        logic [DW-1:0] tmp;
        int            bi;
        logic          ok;
        if (!rst_n) begin
            q.delete();
            mv         = '0;
            merr       = 1'b0;
            prev_stall = 1'b0;
            check("reset_out_valid", out_valid, 0);
        end else begin
            check("bank_valid", bank_valid, mv);
            check("err_sticky", err_sticky, merr);
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("out_without_beat", out_valid, 0);
                end else begin
                    check("out_data", out_data, q[0]);
                    if (out_ready) begin
                        tmp = q.pop_front();
                        n_out++;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                bi = int'(in_bank);
                ok = (bi < NBANKS) && mv[bi];
                e  = '0;
                for (int i = 0; i < LANES; i++) begin
                    e[8*i +: 8] = ok ? mmem[bi][int'(in_data[8*i +: 8])] : 8'h00;
                end
                q.push_back(e);
                n_acc++;
                if (!ok) merr = 1'b1;
            end
            if (cfg_we) mmem[int'(cfg_bank)][int'(cfg_addr)] = cfg_wdata;
            if (cfg_commit) mv[cfg_bank] = 1'b1;
            if (cfg_invalidate) mv[cfg_bank] = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        check("drain_queue_empty", q.size(), 0);
        check("drain_out_valid", out_valid, 0);
    endtask

    task automatic commit_bank(input int b);
        cfg_bank   = BW'(b);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        int k;
        int acc_base;
        int out_base;
        logic accepted;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_bank_valid", bank_valid, 0);
        check("rst_err_sticky", err_sticky, 0);
        check("rst_out_data", out_data, 0);

        // Bank 0: EXP, bank 2: idx^0x5A (left uncommitted), banks 1/3: random.
        for (int b = 0; b < NBANKS; b++) begin
            for (int a = 0; a < 256; a++) begin
                cfg_we    = 1'b1;
                cfg_bank  = BW'(b);
                cfg_addr  = 8'(a);
                cfg_wdata = (b == 0) ? exp_val(8'(a)) : (b == 2) ? (8'(a) ^ 8'h5A) : 8'($urandom);
                tick();
            end
        end
        cfg_we = 1'b0;
        commit_bank(0);
        commit_bank(1);
        commit_bank(3);

        // EXP lookup with latency pinned to the acceptance cycle.
        drain();
        in_valid = 1'b1;
        in_bank  = 0;
        in_data  = 32'h80E0_2000;
        tick();
        in_valid = 1'b0;
        check("exp_not_yet_valid", out_valid, 0);
        tick();
        check("exp_latency_valid", out_valid, 1);
        check("exp_values", out_data, 32'h010C_5720);
        tick();

        // Write to the entry being looked up in the same cycle returns the old byte.
        drain();
        cfg_we    = 1'b1;
        cfg_bank  = 0;
        cfg_addr  = 8'h20;
        cfg_wdata = 8'h11;
        in_valid  = 1'b1;
        in_bank   = 0;
        in_data   = 32'h2020_2020;
        tick();
        cfg_we = 1'b0;
        tick();
        in_valid = 1'b0;
        check("rw_same_cycle_old", out_data, 32'h5757_5757);
        tick();
        check("rw_next_beat_new", out_data, 32'h1111_1111);

        // Eight beats with out_ready low on cycles 3-5.
        drain();
        k        = 0;
        acc_base = n_acc;
        out_base = n_out;
        for (int cy = 0; cy < 30; cy++) begin
            out_ready = !(cy >= 3 && cy <= 5);
            in_valid  = (k < 8);
            in_bank   = 0;
            in_data   = {8'(k + 96), 8'(k + 64), 8'(k + 32), 8'(k)};
            @(negedge clk);
            accepted = in_valid && in_ready;
            if (cy >= 3 && cy <= 5) check("stall_in_ready_low", in_ready, 0);
            tick();
            if (accepted) k++;
        end
        drain();
        check("stream_accepted", n_acc - acc_base, 8);
        check("stream_emitted", n_out - out_base, 8);

        // Commit and invalidate together: invalidate wins.
        cfg_bank       = 1;
        cfg_commit     = 1'b1;
        cfg_invalidate = 1'b1;
        tick();
        cfg_commit     = 1'b0;
        cfg_invalidate = 1'b0;
        check("commit_inval_same_cycle", bank_valid[1], 0);
        commit_bank(1);
        check("banks_before_bank2", bank_valid, 4'b1011);

        // Lookup on never-committed bank 2, then after committing it.
        drain();
        in_valid = 1'b1;
        in_bank  = 2;
        in_data  = 32'h0302_0100;
        tick();
        in_valid = 1'b0;
        check("uncommitted_err_set", err_sticky, 1);
        tick();
        check("uncommitted_valid", out_valid, 1);
        check("uncommitted_zero", out_data, 0);
        repeat (3) tick();
        check("err_held", err_sticky, 1);
        commit_bank(2);
        drain();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("bank2_committed_data", out_data, 32'h5958_5B5A);
        check("err_still_set", err_sticky, 1);

        // Random traffic with concurrent configuration activity.
        for (int cy = 0; cy < 500; cy++) begin
            in_valid       = ($urandom_range(3) != 0);
            in_bank        = BW'($urandom);
            in_data        = DW'($urandom);
            out_ready      = ($urandom_range(3) != 0);
            cfg_we         = ($urandom_range(2) == 0);
            cfg_bank       = BW'($urandom);
            cfg_addr       = 8'($urandom);
            cfg_wdata      = 8'($urandom);
            cfg_commit     = ($urandom_range(15) == 0);
            cfg_invalidate = ($urandom_range(19) == 0);
            tick();
        end
        cfg_we         = 1'b0;
        cfg_commit     = 1'b0;
        cfg_invalidate = 1'b0;
        drain();

        // Reset with two beats in flight.
        commit_bank(0);
        in_valid = 1'b1;
        in_bank  = 0;
        in_data  = DW'($urandom);
        tick();
        tick();
        in_valid = 1'b0;
        check("inflight_before_reset", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_out_valid", out_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_emit_after_reset", out_valid, 0);
        end
        check("bank_valid_after_reset", bank_valid, 0);
        in_valid = 1'b1;
        in_bank  = 0;
        in_data  = 32'h2000_E020;
        tick();
        in_valid = 1'b0;
        check("post_reset_err", err_sticky, 1);
        tick();
        check("post_reset_valid", out_valid, 1);
        check("post_reset_zero", out_data, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/graph_act_lut.md
GRAPH_ACT_LUT -- requirements
Module: graph_act_lut

Interface
REQ-001 Parameter LANES, default 4: number of int8 elements looked up per beat.
REQ-002 Parameter NBANKS, default 4: number of independently loadable 256-entry function tables (EXP, SIGMOID, GELU, user).
REQ-003 Parameter BW, default $clog2(NBANKS): bank-select width.
REQ-004 Port clk, input, 1: single clock; all logic rising-edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port cfg_we, input, 1: table write strobe.
REQ-007 Port cfg_bank, input, BW: bank written.
REQ-008 Port cfg_addr, input, 8: entry written, treated as signed int8 index.
REQ-009 Port cfg_wdata, input, 8: signed int8 entry value.
REQ-010 Port cfg_commit, input, 1: pulse marking cfg_bank as valid for lookup.
REQ-011 Port cfg_invalidate, input, 1: pulse clearing valid bit of cfg_bank.
REQ-012 Port in_valid / in_ready, input / output, 1 each: input handshake.
REQ-013 Port in_bank, input, BW: function selected for this beat.
REQ-014 Port in_data, input, LANES*8: lane i in bits [8i+7:8i].
REQ-015 Port out_valid / out_ready, output / input, 1 each: output handshake.
REQ-016 Port out_data, output, LANES*8: looked-up values, lane order preserved.
REQ-017 Port bank_valid, output, NBANKS: per-bank committed status.
REQ-018 Port err_sticky, output, 1: set on lookup to an uncommitted bank.

Function
REQ-019 Table storage: NBANKS x 256 x 8 bits; no initial contents; every lane reads every bank identically (per-lane read replicas or equivalent).
REQ-020 Write: on a cycle with cfg_we=1, entry [cfg_bank][cfg_addr] takes cfg_wdata; visible to lookups sampled the following cycle or later.
REQ-021 Same-cycle write and lookup of the same entry: lookup returns the old value.
REQ-022 Commit/invalidate: bank_valid[cfg_bank] set by cfg_commit, cleared by cfg_invalidate, one cycle later; both asserted together -> invalidate wins.
REQ-023 Pipeline: two stages, S1 (table read register) and S2 (output register); a beat is accepted when in_valid && in_ready.
REQ-024 Latency: out_valid rises exactly 2 cycles after acceptance when out_ready held 1; throughput 1 beat/cycle.
REQ-025 Stall = out_valid && !out_ready; when stall, S1 and S2 hold and in_ready=0; otherwise in_ready=1.
REQ-026 out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 Bank validity sampled at acceptance: uncommitted bank -> all lanes output 0x00 and err_sticky set the cycle S1 loads.
REQ-028 err_sticky clears only on reset.
REQ-029 Table writes, commit and invalidate are accepted during stall and do not alter data already captured in S1/S2.
REQ-030 in_bank >= NBANKS treated as uncommitted bank (REQ-027).
REQ-031 No arithmetic on data: output equals stored byte, no saturation or sign change.

Reset
REQ-032 rst_n=0 asynchronously clears out_valid, S1 valid, bank_valid, err_sticky; out_data resets to 0; in_ready=1 after reset release.
REQ-033 Reset does not clear table contents; in-flight beats during reset are discarded, not emitted.

Verification
REQ-034 Load bank 0 with EXP (idx/32) table, commit; send lanes {0x00,0x20,0xE0,0x80} bank 0 -> out {0x20,0x57,0x0C,0x01} 2 cycles later.
REQ-035 Stream 8 beats with out_ready low on cycles 3-5 -> in_ready low in those stall cycles, no beat lost or duplicated, order preserved.
REQ-036 Lookup bank 2 never committed -> out all 0x00, err_sticky=1 and held; commit bank 2 then lookup -> stored data, err_sticky still 1.
REQ-037 Write bank0[0x20]=0x11 same cycle as lookup of 0x20 -> 0x57; next beat -> 0x11.
REQ-038 Assert rst_n low with 2 beats in flight -> out_valid=0 immediately, no emission after release; bank 0 lookup without re-commit -> zeros, err_sticky=1.
REQ-039 cfg_commit and cfg_invalidate same cycle on bank 1 -> bank_valid[1]=0.
